// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg
//   Shared constants and types for the ALU request arbiter slice.
//   RESULT_BUS_WIDTH : width of the ALU result beat / response data bus
//   CMD_WIDTH_DEF    : default packed ALU command width
//   ARB_TIMEOUT_W    : width of the inter-beat idle timer
//   arb_state_t      : arbiter FSM state encoding
package alu_req_arbiter_pkg;

    localparam int unsigned RESULT_BUS_WIDTH = 16;
    localparam int unsigned CMD_WIDTH_DEF    = 32;
    localparam int unsigned ARB_TIMEOUT_W    = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_picker.sv
// alu_rr_picker
//   Combinational round-robin selector: finds the first asserted request at or
//   after rr_ptr, wrapping at NUM_REQ-1 back to 0.
//   req_valid  in  NUM_REQ          per-requester valid
//   rr_ptr     in  $clog2(NUM_REQ)  highest-priority index this round
//   any        out 1                at least one request valid
//   grant_idx  out $clog2(NUM_REQ)  selected index (0 when any=0)
module alu_rr_picker
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int unsigned idx;
        any       = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Explicit wrap keeps non-power-of-2 NUM_REQ in range.
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req_valid[idx]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one multi-cycle ALU among NUM_REQ requesters, one transaction in
//   flight. Round-robin grant, command issue, then ownership is held until the
//   ALU result stream ends (last, abort or idle timeout); each result beat is
//   returned to the owner one cycle later.
//   clk, rst (async active-low)
//   req_valid/req_cmd/req_ready      requester command side (req_ready one-hot)
//   alu_cmd_valid/alu_cmd/alu_cmd_ready  ALU command port
//   result_valid/result/result_last/result_rst  ALU result bus
//   rsp_valid/rsp_data/rsp_last/rsp_abort  registered one-hot response to owner
//   busy, owner_id, stray_beat (sticky beat-outside-WAIT flag)
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CMD_WIDTH      = CMD_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           alu_cmd_valid,
    output logic [CMD_WIDTH-1:0]           alu_cmd,
    input  logic                           alu_cmd_ready,
    input  logic                           result_valid,
    input  logic [RESULT_BUS_WIDTH-1:0]    result,
    input  logic                           result_last,
    input  logic                           result_rst,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [RESULT_BUS_WIDTH-1:0]    rsp_data,
    output logic                           rsp_last,
    output logic                           rsp_abort,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     owner_id,
    output logic                           stray_beat
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t                  state, state_d;
    logic [IDX_W-1:0]            rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]            owner_d;
    logic [CMD_WIDTH-1:0]        cmd_q, cmd_d;
    logic [ARB_TIMEOUT_W-1:0]    timer, timer_d;
    logic [NUM_REQ-1:0]          rsp_valid_d;
    logic [RESULT_BUS_WIDTH-1:0] rsp_data_d;
    logic                        rsp_last_d;
    logic                        rsp_abort_d;
    logic                        stray_d;

    logic                        pick_any;
    logic [IDX_W-1:0]            pick_idx;
    logic [CMD_WIDTH-1:0]        cmd_sel;
    logic [NUM_REQ-1:0]          owner_onehot;
    logic [IDX_W-1:0]            rr_next;
    logic                        timeout;

    alu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any       (pick_any),
        .grant_idx (pick_idx)
    );

    assign alu_cmd = cmd_q;
    assign busy    = (state != ARB_IDLE);
    assign rr_next = (owner_id == IDX_W'(NUM_REQ - 1)) ? '0 : owner_id + IDX_W'(1);
    assign timeout = !result_valid && (timer == ARB_TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cmd_sel      = '0;
        owner_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                cmd_sel = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
            end
            owner_onehot[i] = (owner_id == IDX_W'(i));
        end
    end

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        owner_d       = owner_id;
        cmd_d         = cmd_q;
        timer_d       = timer;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data;
        rsp_last_d    = 1'b0;
        rsp_abort_d   = 1'b0;
        stray_d       = stray_beat | (result_valid && (state != ARB_WAIT));
        req_ready     = '0;
        alu_cmd_valid = 1'b0;

        case (state)
            ARB_IDLE: begin
                timer_d = '0;
                if (pick_any) begin
                    owner_d = pick_idx;
                    cmd_d   = cmd_sel;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                alu_cmd_valid = 1'b1;
                // An abort before acceptance leaves the request pending and
                // the pointer untouched, so the same requester is retried.
                if (result_rst) begin
                    state_d = ARB_IDLE;
                end else if (alu_cmd_ready) begin
                    req_ready = owner_onehot;
                    timer_d   = '0;
                    state_d   = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // Abort takes priority over result_last in the same cycle.
                if (result_rst || timeout) begin
                    rsp_valid_d = owner_onehot;
                    rsp_last_d  = 1'b1;
                    rsp_abort_d = 1'b1;
                    rsp_data_d  = result_valid ? result : '0;
                    timer_d     = '0;
                    rr_ptr_d    = rr_next;
                    state_d     = ARB_IDLE;
                end else if (result_valid) begin
                    rsp_valid_d = owner_onehot;
                    rsp_data_d  = result;
                    rsp_last_d  = result_last;
                    timer_d     = '0;
                    if (result_last) begin
                        rr_ptr_d = rr_next;
                        state_d  = ARB_IDLE;
                    end
                end else begin
                    timer_d = timer + ARB_TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            owner_id   <= '0;
            cmd_q      <= '0;
            timer      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            rsp_abort  <= 1'b0;
            stray_beat <= 1'b0;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            owner_id   <= owner_d;
            cmd_q      <= cmd_d;
            timer      <= timer_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            rsp_last   <= rsp_last_d;
            rsp_abort  <= rsp_abort_d;
            stray_beat <= stray_d;
        end
    end

endmodule
